// File: rtl/lockstep_mon_pkg.sv
// Shared types for the lockstep divergence monitor.
// State encoding and check-mode selectors.
package lockstep_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      SYNC,
      RUN,
      DONE
   } state_e;

   localparam int MODE_FINAL  = 0;
   localparam int MODE_WINDOW = 1;

endpackage

// File: rtl/lockstep_divergence_monitor_compare.sv
// Combinational comparison of every copy against copy 0.
// Yields any-divergence and the lowest diverging copy index.
module lockstep_compare
   import lockstep_mon_pkg::*;
#(
   parameter int NUM_COPIES = 2,
   parameter int OBS_W      = 32,
   parameter int CPY_W      = 1
) (
   input  logic [NUM_COPIES-1:0]       obs_valid_i,
   input  logic [NUM_COPIES*OBS_W-1:0] obs_data_i,
   input  logic [OBS_W-1:0]            obs_mask_i,
   output logic                        any_div_o,
   output logic [CPY_W-1:0]            first_copy_o
);

   logic [NUM_COPIES-1:0] div_vec;

   always_comb begin
      div_vec      = '0;
      first_copy_o = '0;
      for (int i = 1; i < NUM_COPIES; i++) begin
         div_vec[i] = (obs_valid_i[i] != obs_valid_i[0]) ||
                      (obs_valid_i[i] && obs_valid_i[0] &&
                       (|((obs_data_i[i*OBS_W +: OBS_W] ^
                           obs_data_i[OBS_W-1:0]) & obs_mask_i)));
      end
      // Scan downwards so the lowest diverging index wins.
      for (int i = NUM_COPIES - 1; i >= 1; i--) begin
         if (div_vec[i]) first_copy_o = CPY_W'(i);
      end
      any_div_o = |div_vec;
   end

endmodule

// File: rtl/lockstep_divergence_monitor.sv
// Reset sequencer and windowed divergence checker for N lock-stepped
// core copies; captures first divergence cycle, copy and a count.
module lockstep_divergence_monitor
   import lockstep_mon_pkg::*;
#(
   parameter int NUM_COPIES   = 2,
   parameter int OBS_W        = 32,
   parameter int CYC_W        = 5,
   parameter int RESET_CYCLES = 2,
   parameter int CHECK_START  = 14,
   parameter int CHECK_END    = 14,
   parameter int MODE         = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [NUM_COPIES-1:0]         obs_valid,
   input  logic [NUM_COPIES*OBS_W-1:0]   obs_data,
   input  logic [OBS_W-1:0]              obs_mask,
   output logic                          core_reset,
   output logic                          sync_pulse,
   output logic                          busy,
   output logic                          done,
   output logic                          diverge,
   output logic [CYC_W-1:0]              diverge_cycle,
   output logic [$clog2(NUM_COPIES)-1:0] diverge_copy,
   output logic [CYC_W-1:0]              diverge_count,
   output logic [CYC_W-1:0]              cycle
);

   localparam int CPY_W = $clog2(NUM_COPIES);
   localparam logic [CYC_W-1:0] CNT_MAX  = {CYC_W{1'b1}};
   localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RESET_CYCLES - 1);
   localparam logic [CYC_W-1:0] C_START  = CYC_W'(CHECK_START);
   localparam logic [CYC_W-1:0] C_END    = CYC_W'(CHECK_END);

   state_e           state_q, state_d;
   logic [CYC_W-1:0] cycle_q, cycle_d;
   logic [CYC_W-1:0] dcyc_q, dcyc_d;
   logic [CYC_W-1:0] dcnt_q, dcnt_d;
   logic [CPY_W-1:0] dcopy_q, dcopy_d;
   logic [CPY_W-1:0] first_copy;
   logic             div_q, div_d;
   logic             busy_q, busy_d;
   logic             any_div;
   logic             check;

   lockstep_compare #(
      .NUM_COPIES (NUM_COPIES),
      .OBS_W      (OBS_W),
      .CPY_W      (CPY_W)
   ) u_cmp (
      .obs_valid_i  (obs_valid),
      .obs_data_i   (obs_data),
      .obs_mask_i   (obs_mask),
      .any_div_o    (any_div),
      .first_copy_o (first_copy)
   );

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      div_d   = div_q;
      dcyc_d  = dcyc_q;
      dcopy_d = dcopy_q;
      dcnt_d  = dcnt_q;
      check   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cycle_d = '0;
            if (start) begin
               state_d = RESET;
               div_d   = 1'b0;
               dcyc_d  = '0;
               dcopy_d = '0;
               dcnt_d  = '0;
            end
         end
         RESET: begin
            cycle_d = cycle_q + CYC_W'(1);
            if (cycle_q == RST_LAST) state_d = SYNC;
         end
         SYNC: begin
            cycle_d = cycle_q + CYC_W'(1);
            state_d = RUN;
         end
         RUN: begin
            cycle_d = cycle_q + CYC_W'(1);
            // RUN never passes C_END, so only the lower bound matters.
            check   = (MODE == MODE_WINDOW) ? (cycle_q >= C_START)
                                            : (cycle_q == C_END);
            if (cycle_q == C_END) state_d = DONE;
         end
         DONE: begin
            cycle_d = '0;
            state_d = IDLE;
         end
         default: begin
            cycle_d = '0;
            state_d = IDLE;
         end
      endcase
      if (check && any_div) begin
         div_d = 1'b1;
         if (!div_q) begin
            dcyc_d  = cycle_q;
            dcopy_d = first_copy;
         end
         if (dcnt_q != CNT_MAX) dcnt_d = dcnt_q + CYC_W'(1);
      end
      busy_d = (state_d == RESET) || (state_d == SYNC) || (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cycle_q <= '0;
         div_q   <= 1'b0;
         dcyc_q  <= '0;
         dcopy_q <= '0;
         dcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         div_q   <= div_d;
         dcyc_q  <= dcyc_d;
         dcopy_q <= dcopy_d;
         dcnt_q  <= dcnt_d;
         busy_q  <= busy_d;
      end
   end

   assign core_reset    = (state_q == IDLE) || (state_q == RESET) ||
                          (state_q == DONE);
   assign sync_pulse    = (state_q == SYNC);
   assign done          = (state_q == DONE);
   assign busy          = busy_q;
   assign diverge       = div_q;
   assign diverge_cycle = dcyc_q;
   assign diverge_copy  = dcopy_q;
   assign diverge_count = dcnt_q;
   assign cycle         = cycle_q;

endmodule
